// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared command and state encodings for the LRU access controller
package cache_pkg;

    typedef enum logic [1:0] {
        LRU_INIT  = 2'b00,
        LRU_TOUCH = 2'b01,
        LRU_AGE   = 2'b10,
        LRU_NOP   = 2'b11
    } lru_cmd_e;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        TOUCH,
        READ,
        OFFER,
        WAIT_FILL
    } ctrl_state_e;

endpackage

// File: rtl/lru_access_ctrl_sat_counter.sv
// rtl/lru_access_ctrl_sat_counter.sv - saturating event counter used for hit/miss statistics
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lru_access_ctrl.sv
// rtl/lru_access_ctrl.sv - sequences lookup results into lru_array init/touch commands and victim offers
module lru_access_ctrl
    import cache_pkg::*;
#(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [INDEX_SIZE-1:0]    req_index,
    input  logic                     req_hit,
    input  logic [$clog2(ASSOC)-1:0] req_way,
    output logic                     victim_valid,
    input  logic                     victim_ready,
    output logic [INDEX_SIZE-1:0]    victim_index,
    output logic [$clog2(ASSOC)-1:0] victim_way,
    input  logic                     fill_done,
    output logic [1:0]               lru_replace,
    output logic [INDEX_SIZE-1:0]    lru_index,
    output logic [$clog2(ASSOC)-1:0] lru_assoc,
    input  logic [$clog2(ASSOC)-1:0] lru_way,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);

    localparam int WAY_W = $clog2(ASSOC);

    ctrl_state_e           state_q, state_d;
    lru_cmd_e              replace_q, replace_d;
    logic                  ready_q, ready_d;
    logic                  vvalid_q, vvalid_d;
    logic [INDEX_SIZE-1:0] index_q, index_d;
    logic [WAY_W-1:0]      assoc_q, assoc_d;
    logic [INDEX_SIZE-1:0] vindex_q, vindex_d;
    logic [WAY_W-1:0]      vway_q, vway_d;
    logic                  accept;

    // Outputs are registered, so each branch computes what is shown in the state being entered;
    // lru_index doubles as the captured request index while the miss is read out.
    always_comb begin
        state_d   = state_q;
        replace_d = LRU_NOP;
        ready_d   = 1'b0;
        vvalid_d  = vvalid_q;
        index_d   = index_q;
        assoc_d   = assoc_q;
        vindex_d  = vindex_q;
        vway_d    = vway_q;
        accept    = 1'b0;
        case (state_q)
            INIT: begin
                replace_d = LRU_INIT;
                state_d   = IDLE;
            end
            IDLE: begin
                if (req_valid && ready_q) begin
                    accept  = 1'b1;
                    index_d = req_index;
                    if (req_hit) begin
                        assoc_d   = req_way;
                        replace_d = LRU_TOUCH;
                        state_d   = TOUCH;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            TOUCH: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            READ: begin
                vvalid_d = 1'b1;
                vindex_d = index_q;
                vway_d   = lru_way;
                state_d  = OFFER;
            end
            OFFER: begin
                // fill_done is deliberately not looked at here: a fill may only follow acceptance
                if (victim_ready) begin
                    vvalid_d = 1'b0;
                    state_d  = WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (fill_done) begin
                    replace_d = LRU_TOUCH;
                    index_d   = vindex_q;
                    assoc_d   = vway_q;
                    state_d   = TOUCH;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            replace_q <= LRU_NOP;
            ready_q   <= 1'b0;
            vvalid_q  <= 1'b0;
            index_q   <= '0;
            assoc_q   <= '0;
            vindex_q  <= '0;
            vway_q    <= '0;
        end else begin
            state_q   <= state_d;
            replace_q <= replace_d;
            ready_q   <= ready_d;
            vvalid_q  <= vvalid_d;
            index_q   <= index_d;
            assoc_q   <= assoc_d;
            vindex_q  <= vindex_d;
            vway_q    <= vway_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept & req_hit),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept & ~req_hit),
        .count (miss_count)
    );

    assign req_ready    = ready_q;
    assign victim_valid = vvalid_q;
    assign victim_index = vindex_q;
    assign victim_way   = vway_q;
    assign lru_replace  = replace_q;
    assign lru_index    = index_q;
    assign lru_assoc    = assoc_q;

endmodule

// File: tb/tb_lru_access_ctrl.sv
// tb/tb_lru_access_ctrl.sv - self-checking bench with age-based lru_array and transaction model
module tb_lru_access_ctrl;

    localparam int ASSOC      = 8;
    localparam int INDEX_SIZE = 7;
    localparam int CNT_WIDTH  = 4;
    localparam int SETS       = 1 << INDEX_SIZE;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [INDEX_SIZE-1:0] req_index;
    logic                  req_hit;
    logic [2:0]            req_way;
    logic                  victim_valid;
    logic                  victim_ready;
    logic [INDEX_SIZE-1:0] victim_index;
    logic [2:0]            victim_way;
    logic                  fill_done;
    logic [1:0]            lru_replace;
    logic [INDEX_SIZE-1:0] lru_index;
    logic [2:0]            lru_assoc;
    logic [2:0]            lru_way;
    logic [CNT_WIDTH-1:0]  hit_count;
    logic [CNT_WIDTH-1:0]  miss_count;

    always #5 clk = ~clk;

    lru_access_ctrl #(
        .ASSOC      (ASSOC),
        .INDEX_SIZE (INDEX_SIZE),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_hit      (req_hit),
        .req_way      (req_way),
        .victim_valid (victim_valid),
        .victim_ready (victim_ready),
        .victim_index (victim_index),
        .victim_way   (victim_way),
        .fill_done    (fill_done),
        .lru_replace  (lru_replace),
        .lru_index    (lru_index),
        .lru_assoc    (lru_assoc),
        .lru_way      (lru_way),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    // lru_array stand-in: per-way age, 0 = MRU, ASSOC-1 = LRU
    int ages [SETS][ASSOC];

    always_comb begin
        lru_way = 3'd0;
        for (int w = 0; w < ASSOC; w++) begin
            if (ages[lru_index][w] == ASSOC - 1) lru_way = 3'(w);
        end
    end

    function automatic logic [2:0] lru_of(input logic [INDEX_SIZE-1:0] s);
        for (int w = 0; w < ASSOC; w++) begin
            if (ages[s][w] == ASSOC - 1) return 3'(w);
        end
        return 3'd0;
    endfunction

    // expected outputs for the cycle after each edge
    logic                  e_ready;
    logic                  e_vv;
    logic [1:0]            e_rep;
    logic [INDEX_SIZE-1:0] e_idx;
    logic [2:0]            e_assoc;
    logic [INDEX_SIZE-1:0] e_vidx;
    logic [2:0]            e_vway;
    int                    e_hit;
    int                    e_miss;
    bit                    init_due;
    int                    miss_stage;   // 0 none, 1 reading LRU, 2 offered, 3 awaiting fill
    logic [1:0]            m_rep;
    bit                    m_acc;

    always @(posedge clk) begin
        if (rst) begin
            e_ready = 1'b0; e_vv = 1'b0; e_rep = 2'b11; e_idx = '0; e_assoc = '0;
            e_vidx = '0; e_vway = '0; e_hit = 0; e_miss = 0;
            init_due = 1'b1; miss_stage = 0;
        end else begin
            m_acc = e_ready && req_valid;
            m_rep = 2'b11;
            if (init_due) begin
                m_rep = 2'b00;
                init_due = 1'b0;
            end else if (m_acc) begin
                e_idx = req_index;
                if (req_hit) begin
                    m_rep = 2'b01;
                    e_assoc = req_way;
                    e_hit = (e_hit >= CNT_MAX) ? CNT_MAX : e_hit + 1;
                end else begin
                    miss_stage = 1;
                    e_miss = (e_miss >= CNT_MAX) ? CNT_MAX : e_miss + 1;
                end
            end else if (miss_stage == 1) begin
                e_vv = 1'b1; e_vidx = e_idx; e_vway = lru_of(e_idx);
                miss_stage = 2;
            end else if (miss_stage == 2 && victim_ready) begin
                e_vv = 1'b0;
                miss_stage = 3;
            end else if (miss_stage == 3 && fill_done) begin
                m_rep = 2'b01; e_idx = e_vidx; e_assoc = e_vway;
                miss_stage = 0;
            end
            e_rep = m_rep;
            e_ready = (m_rep == 2'b11) && (miss_stage == 0);
        end
        if (lru_replace == 2'b00) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < ASSOC; w++) ages[s][w] <= w;
        end else if (lru_replace == 2'b01) begin
            for (int w = 0; w < ASSOC; w++)
                if (ages[lru_index][w] < ages[lru_index][lru_assoc]) ages[lru_index][w] <= ages[lru_index][w] + 1;
            ages[lru_index][lru_assoc] <= 0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("victim_valid", 32'(victim_valid), 32'(e_vv));
        chk("lru_replace", 32'(lru_replace), 32'(e_rep));
        chk("lru_index", 32'(lru_index), 32'(e_idx));
        chk("lru_assoc", 32'(lru_assoc), 32'(e_assoc));
        chk("victim_index", 32'(victim_index), 32'(e_vidx));
        chk("victim_way", 32'(victim_way), 32'(e_vway));
        chk("hit_count", 32'(hit_count), 32'(e_hit));
        chk("miss_count", 32'(miss_count), 32'(e_miss));
    endtask

    int acc;
    int inits;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_way = '0;
        victim_ready = 1'b0; fill_done = 1'b0;
        repeat (3) tick();
        chk("reset_replace", 32'(lru_replace), 32'd3);
        chk("reset_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("init_cmd", 32'(lru_replace), 32'd0);
        tick();
        chk("after_init_nop", 32'(lru_replace), 32'd3);
        chk("after_init_ready", 32'(req_ready), 32'd1);

        req_valid = 1'b1; req_index = 7'd5; req_hit = 1'b1; req_way = 3'd3;
        tick();
        req_valid = 1'b0;
        chk("hit_touch_cmd", 32'(lru_replace), 32'd1);
        chk("hit_touch_index", 32'(lru_index), 32'd5);
        chk("hit_touch_assoc", 32'(lru_assoc), 32'd3);
        chk("hit_count_one", 32'(hit_count), 32'd1);
        tick();
        chk("set5_way3_mru", 32'(ages[5][3]), 32'd0);
        chk("ready_after_touch", 32'(req_ready), 32'd1);

        req_valid = 1'b1; req_index = 7'd9; req_hit = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("miss_count_one", 32'(miss_count), 32'd1);
        tick();
        chk("victim_offer", 32'(victim_valid), 32'd1);
        chk("victim_way_init", 32'(victim_way), 32'd7);
        chk("victim_index_9", 32'(victim_index), 32'd9);
        repeat (4) begin
            tick();
            chk("victim_hold_valid", 32'(victim_valid), 32'd1);
            chk("victim_hold_way", 32'(victim_way), 32'd7);
            chk("victim_hold_index", 32'(victim_index), 32'd9);
        end
        victim_ready = 1'b1; fill_done = 1'b1;
        tick();
        victim_ready = 1'b0; fill_done = 1'b0;
        chk("victim_taken", 32'(victim_valid), 32'd0);
        tick();
        chk("early_fill_ignored", 32'(lru_replace), 32'd3);
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        chk("fill_touch_cmd", 32'(lru_replace), 32'd1);
        chk("fill_touch_index", 32'(lru_index), 32'd9);
        chk("fill_touch_assoc", 32'(lru_assoc), 32'd7);
        tick();
        req_valid = 1'b1; req_index = 7'd9; req_hit = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("second_victim_way", 32'(victim_way), 32'd6);
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_victim_valid", 32'(victim_valid), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        tick();
        chk("reinit_cmd", 32'(lru_replace), 32'd0);
        tick();
        chk("reinit_ready", 32'(req_ready), 32'd1);

        acc = 0; inits = 0;
        req_valid = 1'b1; req_hit = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) acc++;
            req_index = 7'($urandom_range(0, SETS - 1));
            req_way = 3'($urandom_range(0, ASSOC - 1));
            tick();
            if (lru_replace == 2'b00) inits++;
        end
        req_valid = 1'b0;
        chk("stream_accepts", 32'(acc), 32'd20);
        chk("stream_no_init", 32'(inits), 32'd0);
        chk("hit_saturated", 32'(hit_count), 32'd15);
        chk("stream_miss_zero", 32'(miss_count), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_hit = ($urandom_range(0, 2) != 0);
            req_index = 7'($urandom_range(0, 15));
            req_way = 3'($urandom_range(0, ASSOC - 1));
            victim_ready = ($urandom_range(0, 2) == 0);
            fill_done = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; victim_ready = 1'b0; fill_done = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
